x_uart_rx: RTL and testbench
============================

Name: x_uart_rx

Overview:
- UART receiver, 8N1, LSB first, idle-high line; the receive-side counterpart of the team's UART transmitter, using the same baud arithmetic.
- Oversamples the asynchronous serial input, validates the start bit at mid-bit, and samples data and stop bits at bit centres.
- Presents each received byte with a one-cycle valid pulse to downstream logic (command decoder / delay-line control).

Parameters:
- p_clk_hz, 12000000, system clock frequency in Hz.
- p_baud, 115200, line baud rate.
- Derived localparams:
  - p_timer_top = p_clk_hz / p_baud (integer divide); bit period = p_timer_top+1 cycles (105 at defaults).
  - p_timer_half = p_timer_top / 2 (52 at defaults).
  - p_timer_width = $clog2(p_timer_top+1).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_rx  input  1  serial line, asynchronous to i_clk.
- o_data  output  8  last received byte; held until the next valid byte.
- o_valid  output  1  one-cycle pulse; o_data is valid in the same cycle.
- o_frame_err  output  1  present only with X_UART_RX_FRAME_ERR_EN; one-cycle pulse.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_frame_err=0, state=IDLE, timer=0, both synchroniser flops=1 (idle line).
- Synchroniser:
  - 2-flop synchroniser on i_rx; all logic uses the synchronised value rx_s.
  - Pin-to-rx_s delay is 2 cycles.
- Timer:
  - Counts 0..p_timer_top, wraps to 0; enabled in every state except IDLE and WAIT_HIGH.
  - Forced to 0 on every transition out of IDLE and out of START.
- States and transitions:
  - IDLE: rx_s==0 -> START (timer=0).
  - START: at timer==p_timer_half sample rx_s. If 0 -> D0 (timer=0). If 1 -> IDLE (glitch rejected, no output).
  - D0..D7: at timer==p_timer_top, shift rx_s into bit k of the data shift register, then go to the next state. D7 -> STOP.
  - STOP: at timer==p_timer_top sample rx_s.
    - If 1: load o_data from the shift register, pulse o_valid in the next cycle, go to IDLE.
    - If 0: framing error; no o_valid, o_data unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. A held-low break must not be decoded as a stream of 0x00 bytes.
- Latency:
  - Take cycle 0 as the first cycle IDLE sees rx_s==0.
  - START sample occurs at cycle 1+p_timer_half.
  - Dk sample occurs at cycle 1+p_timer_half+(k+1)(p_timer_top+1).
  - o_valid is high in cycle 2+p_timer_half+9(p_timer_top+1), which is cycle 999 at defaults.
- Handshake: no backpressure; o_valid is never held more than 1 cycle. A consumer that misses the pulse loses the byte.
- Back-to-back frames: IDLE is re-entered about half a bit before the end of the stop bit, so a start bit that follows immediately is detected.
- Reset mid-frame: immediately returns to IDLE. A partial byte is discarded and no valid is emitted. The next falling edge after reset release starts a new frame.

Optional Feature:
- Macro: X_UART_RX_FRAME_ERR_EN.
- Defined:
  - Port o_frame_err exists.
  - Pulses high for 1 cycle in the same cycle o_valid would have fired when the stop bit samples 0.
- Undefined:
  - Port absent and no error logic is built.
  - The WAIT_HIGH state and the byte discard on a bad stop bit are still required.

Decomposition:
- Package x_uart_pkg holds:
  - the RX state enum (IDLE, WAIT_HIGH, START, D0..D7, STOP);
  - a function computing timer top from (clk_hz, baud), for use by both TX and RX.
- Sub-module x_sync2: generic 2-flop synchroniser with a reset-value parameter (1 here). It is reused for other async inputs.

Test Plan:
- Drive byte 0xA5 at 115200 baud from the team's UART transmitter (defaults) -> exactly one o_valid, o_data=0xA5, zero o_frame_err.
- Drive 0x00, 0xFF, 0x55, 0x80 back-to-back with no idle gap -> four o_valid pulses in order with the matching data; none are dropped.
- Drive a 30-cycle low glitch on i_rx -> state returns to IDLE, with no o_valid and no o_frame_err.
- Drive a frame 0x3C with the stop bit forced low, then hold low for 3 bit times, then high, then a valid 0x12 -> o_frame_err pulse once (macro on), no o_valid for 0x3C, then o_data=0x12 with o_valid.
- Assert i_rst during D4 of a frame, release, then send 0x7E -> no output for the aborted frame; the next o_valid carries 0x7E.
- Check latency: measure o_valid exactly 999 cycles after the first cycle rx_s is low (+2 from the pin); also check baud ±2% skew between TX and RX clocks still decodes 0xC3.

Source files
------------

// File: rtl/x_uart_pkg.sv
// Shared UART definitions: RX state encoding and the baud timer arithmetic used by both TX and RX.
`timescale 1ns/1ps
package x_uart_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_HIGH,
        S_START,
        S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7,
        S_STOP
    } rx_state_e;

    // Bit period is (top + 1) clocks; TX and RX must agree on this.
    function automatic int unsigned f_timer_top(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/x_uart_rx_if.sv
// Received-byte output bus of x_uart_rx. o_frame_err exists only with X_UART_RX_FRAME_ERR_EN.
`timescale 1ns/1ps
interface x_uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
`ifdef X_UART_RX_FRAME_ERR_EN
    logic       o_frame_err;

    modport master (output o_data, output o_valid, output o_frame_err);
    modport slave  (input  o_data, input  o_valid, input  o_frame_err);
`else
    modport master (output o_data, output o_valid);
    modport slave  (input  o_data, input  o_valid);
`endif
endinterface

// File: rtl/x_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input; reset value is a parameter.
`timescale 1ns/1ps
module x_sync2 #(
    parameter bit p_rst_val = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= p_rst_val;
            r_sync <= p_rst_val;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/x_uart_rx.sv
// 8N1 UART receiver: start bit validated at mid-bit, data/stop sampled at bit centres.
// Optional X_UART_RX_FRAME_ERR_EN adds a one-cycle o_frame_err pulse on a bad stop bit.
`timescale 1ns/1ps
module x_uart_rx
    import x_uart_pkg::*;
#(
    parameter int unsigned p_clk_hz = 12000000,
    parameter int unsigned p_baud   = 115200
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rx,
    x_uart_rx_if.master    rx_if
);
    localparam int unsigned p_timer_top   = f_timer_top(p_clk_hz, p_baud);
    localparam int unsigned p_timer_half  = p_timer_top / 2;
    localparam int unsigned p_timer_width = $clog2(p_timer_top + 1);

    localparam logic [p_timer_width-1:0] lp_top  = p_timer_width'(p_timer_top);
    localparam logic [p_timer_width-1:0] lp_half = p_timer_width'(p_timer_half);

    logic                     w_rx_s;
    rx_state_e                r_state;
    rx_state_e                w_state_nxt;
    logic [p_timer_width-1:0] r_timer;
    logic                     w_top_hit;
    logic                     w_half_hit;
    logic                     w_timer_clr;
    logic                     w_shift;
    logic                     w_load;
    logic [7:0]               r_shift;
    logic [7:0]               r_data;
    logic                     r_valid;

    x_sync2 #(.p_rst_val(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    assign w_top_hit  = (r_timer == lp_top);
    assign w_half_hit = (r_timer == lp_half);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_clr = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_timer_clr = 1'b1;
                end
            end
            S_START: begin
                if (w_half_hit) begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = w_rx_s ? S_IDLE : S_D0;
                end
            end
            S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7: begin
                // Enum order makes D7 + 1 == STOP.
                if (w_top_hit) begin
                    w_shift     = 1'b1;
                    w_state_nxt = rx_state_e'(r_state + 4'd1);
                end
            end
            S_STOP: begin
                if (w_top_hit) begin
                    if (w_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held-low break waits here instead of decoding as 0x00 bytes.
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (w_timer_clr || r_state == S_IDLE || r_state == S_WAIT_HIGH || w_top_hit) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_shift) r_shift <= {w_rx_s, r_shift[7:1]};
            if (w_load)  r_data  <= r_shift;
            r_valid <= w_load;
        end
    end

    assign rx_if.o_data  = r_data;
    assign rx_if.o_valid = r_valid;

`ifdef X_UART_RX_FRAME_ERR_EN
    logic r_frame_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_frame_err <= 1'b0;
        else       r_frame_err <= (r_state == S_STOP) && w_top_hit && !w_rx_s;
    end

    assign rx_if.o_frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_x_uart_rx.sv
// Self-checking bench for x_uart_rx: table-driven frames, corner sequences, randomized skewed traffic vs a frame model.
`timescale 1ns/1ps
module tb_x_uart_rx;
    localparam int unsigned CLK_HZ  = 12000000;
    localparam int unsigned BAUD    = 115200;
    localparam int          BIT_CYC = CLK_HZ / BAUD + 1;
    localparam realtime     TCLK    = 10.0;
    localparam realtime     BIT_T   = BIT_CYC * TCLK;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_rx;

    always #(TCLK / 2) i_clk = ~i_clk;

    x_uart_rx_if u_if ();

    x_uart_rx #(.p_clk_hz(CLK_HZ), .p_baud(BAUD)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_rx  (i_rx),
        .rx_if (u_if)
    );

    int checks = 0;
    int errors = 0;
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int  ferr_cnt  = 0;
    int  exp_ferr  = 0;
    bit  prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge i_clk) begin
        if (u_if.o_valid === 1'b1) begin
            check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            got_q.push_back(u_if.o_data);
        end
        prev_valid = u_if.o_valid;
`ifdef X_UART_RX_FRAME_ERR_EN
        if (u_if.o_frame_err === 1'b1) ferr_cnt++;
`endif
    end

    // Drives one 8N1 frame; the model decodes the same bit sequence by the framing rules.
    task automatic send_frame(input logic [7:0] d, input bit stop, input realtime bt, input bit aborted);
        bit          f[10];
        logic [7:0]  dec;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        f[9] = stop;
        for (int i = 0; i < 10; i++) begin
            i_rx = f[i];
            #(bt);
        end
        if (!aborted) begin
            dec = '0;
            for (int i = 1; i <= 8; i++) dec[i-1] = f[i];
            if (f[0] == 1'b0 && f[9] == 1'b1) exp_q.push_back(dec);
            else                              exp_ferr++;
        end
    endtask

    task automatic compare_model(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({name, "_data"}, (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF, {24'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cnt;
        bit found;
        int idx;
        int n_exp;

        vecs[0] = '{8'h00, 1'b1, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 8'hFF};
        vecs[2] = '{8'h55, 1'b1, 8'h55};
        vecs[3] = '{8'h80, 1'b1, 8'h80};
        vecs[4] = '{8'h01, 1'b1, 8'h01};
        vecs[5] = '{8'hC3, 1'b1, 8'hC3};

        // Reset state
        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (5) @(negedge i_clk);
        check("rst_data", u_if.o_data, 32'h00);
        check("rst_valid", u_if.o_valid, 32'h0);
`ifdef X_UART_RX_FRAME_ERR_EN
        check("rst_frame_err", u_if.o_frame_err, 32'h0);
`endif
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        check("post_rst_valid", u_if.o_valid, 32'h0);

        // Latency: pin falls before posedge 1, o_valid must be seen after posedge 2+999
        cnt = 0;
        found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, BIT_T, 1'b0);
            begin
                for (int k = 0; k < 1200 && !found; k++) begin
                    @(posedge i_clk);
                    cnt++;
                    @(negedge i_clk);
                    if (u_if.o_valid === 1'b1) found = 1'b1;
                end
            end
        join
        check("latency_seen", {31'd0, found}, 32'd1);
        check("latency_cycles", cnt, 32'd1001);
        #(2 * BIT_T);
        compare_model("a5");
        check("a5_no_ferr", ferr_cnt, 32'd0);

        // Back-to-back table, no idle gap between frames
        foreach (vecs[i]) send_frame(vecs[i].data, 1'b1, BIT_T, 1'b0);
        #(2 * BIT_T);
        idx = 0;
        n_exp = 0;
        foreach (vecs[i]) begin
            if (vecs[i].exp_valid) begin
                check("b2b_data", (idx < got_q.size()) ? {24'd0, got_q[idx]} : 32'hDEAD_BEEF, {24'd0, vecs[i].exp_data});
                idx++;
                n_exp++;
            end
        end
        check("b2b_count", got_q.size(), n_exp);
        got_q.delete();
        exp_q.delete();

        // 30-cycle glitch is rejected at the start-bit centre
        @(negedge i_clk);
        i_rx = 1'b0;
        repeat (30) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (3 * BIT_CYC) @(negedge i_clk);
        check("glitch_no_valid", got_q.size(), 32'd0);
        check("glitch_no_ferr", ferr_cnt, 32'd0);
        got_q.delete();

        // Bad stop bit, line held low 3 bits, then a good frame
        send_frame(8'h3C, 1'b0, BIT_T, 1'b0);
        #(3 * BIT_T);
        i_rx = 1'b1;
        #(BIT_T);
        send_frame(8'h12, 1'b1, BIT_T, 1'b0);
        #(2 * BIT_T);
        compare_model("ferr_seq");
        check("ferr_seq_data_held", u_if.o_data, 32'h12);
`ifdef X_UART_RX_FRAME_ERR_EN
        check("ferr_pulses", ferr_cnt, exp_ferr);
`endif

        // Reset during D4 of an aborted frame, then a clean 0x7E
        @(negedge i_clk);
        fork
            send_frame(8'hF0, 1'b1, BIT_T, 1'b1);
            begin
                repeat (530) @(negedge i_clk);
                i_rst = 1'b1;
                @(negedge i_clk);
                check("midrst_data", u_if.o_data, 32'h00);
                check("midrst_valid", u_if.o_valid, 32'h0);
                repeat (2) @(negedge i_clk);
                i_rst = 1'b0;
            end
        join
        #(BIT_T);
        send_frame(8'h7E, 1'b1, BIT_T, 1'b0);
        #(2 * BIT_T);
        compare_model("midrst");

        // +/-2% baud skew between transmitter and receiver
        send_frame(8'hC3, 1'b1, BIT_T * 1.02, 1'b0);
        #(BIT_T);
        send_frame(8'hC3, 1'b1, BIT_T * 0.98, 1'b0);
        #(2 * BIT_T);
        compare_model("skew");

        // Randomized bytes, skew and gaps against the frame model
        for (int n = 0; n < 24; n++) begin
            int sk;
            int gap;
            sk  = int'($urandom_range(30)) - 15;
            gap = int'($urandom_range(2));
            send_frame(8'($urandom), 1'b1, BIT_T * (1000 + sk) / 1000.0, 1'b0);
            if (gap != 0) #(gap * BIT_T / 2);
        end
        #(2 * BIT_T);
        compare_model("random");
`ifdef X_UART_RX_FRAME_ERR_EN
        check("final_ferr", ferr_cnt, exp_ferr);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
